memory: RTL and testbench
=========================

Name: memory

Overview:
- Single-port, byte-wide, 256-entry data RAM for the processor's memory stage.
- Writes are synchronous to the clock edge; reads are combinational, so load data is available in the same cycle the address is presented.
- Asynchronous active-low reset clears the entire array to zero.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of the data ports.
- ADDR_WIDTH, 8, width of the address port.
- DEPTH, 256 (2**ADDR_WIDTH), number of words; every address value maps to a unique word.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 clears the array.
- address  input  ADDR_WIDTH  word address, shared by read and write.
- mem_read  input  1  read enable; 1 drives addressed word onto out_data.
- mem_write  input  1  write enable; 1 stores write_data at address on the rising clk edge.
- write_data  input  DATA_WIDTH  data to store.
- out_data  output  DATA_WIDTH  read data.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array. No latency on read; one clock edge for write.
- Reset:
  - rst=0 asynchronously forces every word to 0, regardless of clk.
  - Reset holds while rst=0; writes are ignored during reset.
  - out_data reads 0 during and after reset until a location is written.
- Write: on posedge clk with rst=1 and mem_write=1, mem[address] <= write_data. With mem_write=0, the array is unchanged.
- Read:
  - out_data = mem[address] combinationally while mem_read=1.
  - Changes in address, mem_read or array contents propagate without waiting for a clock edge.
- Read disabled: out_data = 0 whenever mem_read=0.
- Simultaneous mem_read=1 and mem_write=1:
  - The write occurs at the edge.
  - Before the edge, out_data shows the old contents; after the edge, it shows the new value (read-after-write, no bypass).
- Overwrite: a later write to the same address fully replaces the prior value.
- Address range: all 2**ADDR_WIDTH values are valid; no wrap or out-of-range case exists.
- Reset mid-operation: an asserted rst overrides a pending write in the same cycle; the array ends at all zeros.
- No X propagation from uninitialised storage; every word is defined after the first reset.

Test Plan:
- Reset: hold rst=0 for 20 ns, release. Then read addresses 0x00, 0x10, 0xFF with mem_read=1 -> out_data=0x00 each.
- Write/read: write 0xAA to 0x10 (mem_write=1 for one rising edge), then read 0x10 -> 0xAA within 1 ns of address/mem_read settling. Write 0x55 to 0x20, read 0x20 -> 0x55, and 0x10 still reads 0xAA.
- Overwrite: write 0x0F to 0x10 -> reading 0x10 gives 0x0F. Unwritten 0x30 still reads 0x00.
- Read enable gating: with 0x10=0x0F, deassert mem_read -> out_data=0x00; reassert -> 0x0F with no clock edge required.
- Same-cycle read/write: mem_read=1, mem_write=1, address 0x40, write_data 0x3C.
  - Before the edge, out_data=0x00.
  - After the rising edge, out_data=0x3C.
  - With mem_write=0, changing write_data has no effect.
- Async reset mid-run: after writing several addresses, pulse rst=0 between clock edges -> all locations immediately read 0x00. A write asserted during reset is discarded.

Source files
------------

// File: rtl/memory.sv
// Byte-wide single-port data RAM for the memory stage: synchronous write,
// combinational read, asynchronous active-low clear of the whole array.
module memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wins over a write pending in the same cycle, leaving the array all zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[address] <= write_data;
    end
  end

  // No write bypass: a same-cycle read shows the old word until the edge.
  assign out_data = mem_read ? mem[address] : '0;

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: stimulus queues expected read data, a monitor
// samples out_data after it settles and compares.
module tb_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] write_data;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q  [$];
  string      name_q [$];

  memory #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .write_data (write_data),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  // Monitor: each queued expectation is compared 1 ns after it is issued.
  initial begin
    forever begin
      wait (exp_q.size() > 0);
      #1;
      begin
        logic [7:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total++;
        if (out_data !== e) begin
          bad++;
          $display("FAIL %s: out_data=%02h expected=%02h", n, out_data, e);
        end
      end
    end
  end

  task automatic expect_rd(input string nm, input logic [7:0] a, input logic rd,
                           input logic [7:0] e);
    address  = a;
    mem_read = rd;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #3;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    write_data = d;
    mem_write  = 1'b1;
    @(posedge clk);
    #1;
    mem_write  = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    address    = 8'h00;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    write_data = 8'h00;
    #2;
    expect_rd("rst_hold_00", 8'h00, 1'b1, 8'h00);
    #15;
    rst = 1'b1;

    @(negedge clk);
    expect_rd("reset_00", 8'h00, 1'b1, 8'h00);
    expect_rd("reset_10", 8'h10, 1'b1, 8'h00);
    expect_rd("reset_ff", 8'hFF, 1'b1, 8'h00);

    wr(8'h10, 8'hAA);
    expect_rd("wr_10_AA", 8'h10, 1'b1, 8'hAA);
    wr(8'h20, 8'h55);
    expect_rd("wr_20_55", 8'h20, 1'b1, 8'h55);
    expect_rd("keep_10_AA", 8'h10, 1'b1, 8'hAA);
    wr(8'hFF, 8'hC3);
    expect_rd("wr_ff_C3", 8'hFF, 1'b1, 8'hC3);
    expect_rd("keep_00", 8'h00, 1'b1, 8'h00);

    wr(8'h10, 8'h0F);
    expect_rd("overwrite_10", 8'h10, 1'b1, 8'h0F);
    expect_rd("unwritten_30", 8'h30, 1'b1, 8'h00);

    expect_rd("rd_off_10", 8'h10, 1'b0, 8'h00);
    expect_rd("rd_off_20", 8'h20, 1'b0, 8'h00);
    expect_rd("rd_on_10", 8'h10, 1'b1, 8'h0F);

    // Same-cycle read and write
    @(negedge clk);
    address    = 8'h40;
    write_data = 8'h3C;
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    exp_q.push_back(8'h00);
    name_q.push_back("rw_before_edge");
    #3;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    expect_rd("rw_after_edge", 8'h40, 1'b1, 8'h3C);
    write_data = 8'hFF;
    @(posedge clk);
    #1;
    expect_rd("no_write_when_off", 8'h40, 1'b1, 8'h3C);

    // Asynchronous reset between edges, with a write held during reset
    @(negedge clk);
    #2;
    rst        = 1'b0;
    address    = 8'h50;
    write_data = 8'h77;
    mem_write  = 1'b1;
    expect_rd("async_rst_10", 8'h10, 1'b1, 8'h00);
    expect_rd("async_rst_20", 8'h20, 1'b1, 8'h00);
    expect_rd("async_rst_40", 8'h40, 1'b1, 8'h00);
    expect_rd("async_rst_ff", 8'hFF, 1'b1, 8'h00);
    address = 8'h50;
    @(posedge clk);
    #1;
    expect_rd("rst_write_ignored_in", 8'h50, 1'b1, 8'h00);
    @(negedge clk);
    mem_write = 1'b0;
    #1;
    rst = 1'b1;
    expect_rd("rst_write_ignored", 8'h50, 1'b1, 8'h00);
    wr(8'h50, 8'h99);
    expect_rd("post_rst_write", 8'h50, 1'b1, 8'h99);

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 100) begin
        #1;
        waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: pending=%0d required=0", exp_q.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
